step_move_sequencer: RTL and testbench

//  Move-command scheduler for the stepper path: accepts {dir, step count, target period},

---
 rtl/step_move_sequencer.sv | 154 +++++++++++++++
 tb/tb_step_move_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/step_move_sequencer.sv
// step_move_sequencer: trapezoidal-profile step pulse scheduler with abort and done handshake.
// Optional POSITION_TRACK_EN adds a signed step position counter (pos_out, pos_clr).
module step_move_sequencer #(
    parameter int STEP_W    = 16,
    parameter int DIV_W     = 21,
    parameter int START_DIV = 1000,
    parameter int MIN_DIV   = 50,
    parameter int ACCEL_DEC = 10
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [STEP_W-1:0]  cmd_steps,
    input  logic [DIV_W-1:0]   cmd_div,
    input  logic               abort,
    output logic               step_pulse,
    output logic               dir_out,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [STEP_W-1:0]  steps_left
`ifdef POSITION_TRACK_EN
    ,
    input  logic               pos_clr,
    output logic signed [31:0] pos_out
`endif
);
    localparam logic [DIV_W-1:0] START = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] MIN   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEC   = DIV_W'(ACCEL_DEC);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, FIN} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  cur, cur_n, tgt, tgt_n, tick, tick_n, div_c;
    logic [STEP_W-1:0] ramp, ramp_n, left_n;
    logic              dir_n, pulse_n, done_n, aborted_n, fire;

    // one ramp step slower, capped at the start period without overflowing
    function automatic logic [DIV_W-1:0] slow(input logic [DIV_W-1:0] p);
        return (START < DEC || p >= START - DEC) ? START : p + DEC;
    endfunction

    function automatic logic [STEP_W-1:0] ramp_dn(input logic [STEP_W-1:0] r);
        return (r == '0) ? '0 : r - STEP_W'(1);
    endfunction

    always_comb begin
        state_n   = state;
        cur_n     = cur;
        tgt_n     = tgt;
        tick_n    = tick;
        ramp_n    = ramp;
        left_n    = steps_left;
        dir_n     = dir_out;
        pulse_n   = 1'b0;
        done_n    = 1'b0;
        aborted_n = aborted;
        fire      = 1'b0;
        div_c     = (cmd_div < MIN) ? MIN : cmd_div;
        case (state)
            IDLE: if (cmd_valid) begin
                tgt_n     = div_c;
                cur_n     = (div_c < START) ? START : div_c;
                tick_n    = '0;
                ramp_n    = '0;
                left_n    = cmd_steps;
                dir_n     = cmd_dir;
                aborted_n = 1'b0;
                done_n    = (cmd_steps == '0);
                state_n   = (cmd_steps == '0) ? IDLE : (div_c < START) ? ACCEL : CRUISE;
            end
            FIN: begin
                state_n   = IDLE;
                done_n    = 1'b1;
                aborted_n = aborted | abort;
            end
            default: begin
                fire   = (tick >= cur - DIV_W'(1));
                tick_n = fire ? '0 : tick + DIV_W'(1);
                if (fire) begin
                    pulse_n = 1'b1;
                    left_n  = steps_left - STEP_W'(1);
                    if (left_n == '0)
                        state_n = FIN;
                    else if (state == ACCEL && left_n > ramp) begin
                        cur_n   = (cur - tgt > DEC) ? cur - DEC : tgt;
                        ramp_n  = ramp + STEP_W'(1);
                        state_n = (cur_n == tgt) ? CRUISE : ACCEL;
                    end else if (state != CRUISE || left_n <= ramp) begin
                        cur_n   = slow(cur);
                        ramp_n  = ramp_dn(ramp);
                        state_n = DECEL;
                    end
                end
                // abort acts on the post-pulse result; entering DECEL applies the entry step
                if (abort) begin
                    aborted_n = 1'b1;
                    if (state_n != FIN) begin
                        if (ramp_n < left_n) left_n = ramp_n;
                        if (state_n != DECEL) begin
                            cur_n  = slow(cur_n);
                            ramp_n = ramp_dn(ramp_n);
                        end
                        state_n = (left_n != '0) ? DECEL : fire ? FIN : IDLE;
                        done_n  = (left_n == '0) && !fire;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            cur        <= '0;
            tgt        <= '0;
            tick       <= '0;
            ramp       <= '0;
            steps_left <= '0;
            dir_out    <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            tgt        <= tgt_n;
            tick       <= tick_n;
            ramp       <= ramp_n;
            steps_left <= left_n;
            dir_out    <= dir_n;
            step_pulse <= pulse_n;
            done       <= done_n;
            aborted    <= aborted_n;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef POSITION_TRACK_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            pos_out <= '0;
        else if (pos_clr)
            pos_out <= '0;
        else if (step_pulse)
            pos_out <= dir_out ? pos_out + 32'sd1 : pos_out - 32'sd1;
    end
`endif
endmodule

// File: tb/tb_step_move_sequencer.sv
// tb_step_move_sequencer: directed and random moves checked against an event-level profile model.
module tb_step_move_sequencer;
    localparam int SW = 16, DW = 21, START = 100, MIN = 20, DEC = 20;

    logic          clk = 1'b0, resetb = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic [DW-1:0] cmd_div = '0;
    logic          cmd_ready, step_pulse, dir_out, busy, done, aborted;
    logic [SW-1:0] steps_left;
`ifdef POSITION_TRACK_EN
    logic               pos_clr = 1'b0;
    logic signed [31:0] pos_out;
`endif
    int exp_pos = 0;
    int n_checks = 0, n_fail = 0;
    int exp_t[$], exp_left[$];
    int done_t, abort_t;
    bit exp_ab;

    always #5 clk = ~clk;

    step_move_sequencer #(.STEP_W(SW), .DIV_W(DW), .START_DIV(START), .MIN_DIV(MIN), .ACCEL_DEC(DEC)) dut (
        .clk(clk), .resetb(resetb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_div(cmd_div), .abort(abort), .step_pulse(step_pulse),
        .dir_out(dir_out), .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
`ifdef POSITION_TRACK_EN
        , .pos_clr(pos_clr), .pos_out(pos_out)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse times (cycles after accept), steps_left at each pulse, done time; abort after pulse ab_k + ab_d clk.
    task automatic model(input int steps, input int div, input int ab_k, input int ab_d);
        int tgt, cur, ramp, left, ph, t, k;
        exp_t.delete();
        exp_left.delete();
        exp_ab  = 0;
        abort_t = -1;
        done_t  = 0;
        tgt  = div < MIN ? MIN : div;
        cur  = tgt < START ? START : tgt;
        ramp = 0;
        left = steps;
        ph   = cur > tgt ? 0 : 1;
        t    = 0;
        k    = 0;
        while (left > 0) begin
            if (k == ab_k) begin
                exp_ab  = 1;
                abort_t = t + ab_d;
                left    = left < ramp ? left : ramp;
                if (ph != 2) begin
                    cur  = cur + DEC > START ? START : cur + DEC;
                    ramp = ramp > 0 ? ramp - 1 : 0;
                end
                ph = 2;
                if (left == 0) begin
                    done_t = abort_t;
                    return;
                end
            end
            t += cur;
            left--;
            k++;
            exp_t.push_back(t);
            exp_left.push_back(left);
            if (left == 0) begin
                done_t = t + 1;
                return;
            end
            if (ph == 0 && left > ramp) begin
                cur = cur - DEC < tgt ? tgt : cur - DEC;
                ramp++;
                if (cur == tgt) ph = 1;
            end else if (ph == 2 || left <= ramp) begin
                ph   = 2;
                cur  = cur + DEC > START ? START : cur + DEC;
                ramp = ramp > 0 ? ramp - 1 : 0;
            end
        end
    endtask

    task automatic run_move(input int steps, input int div, input bit dir, input int ab_k, input int ab_d);
        int pi;
        pi = 0;
        model(steps, div, ab_k, ab_d);
        cmd_valid = 1'b1;
        cmd_steps = SW'(steps);
        cmd_div   = DW'(div);
        cmd_dir   = dir;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("dir_out", dir_out, dir);
        check("aborted_clr", aborted, 0);
        for (int n = 0; n <= done_t; n++) begin
            if (n > 0) @(negedge clk);
            abort = (n == abort_t - 1);
            check("step_pulse", step_pulse, pi < exp_t.size() && exp_t[pi] == n);
            if (pi < exp_t.size() && exp_t[pi] == n) begin
                check("steps_left", steps_left, exp_left[pi]);
                pi++;
            end
            check("done", done, n == done_t);
            check("busy", busy, n < done_t);
            check("cmd_ready", cmd_ready, n >= done_t);
        end
        abort = 1'b0;
        check("aborted", aborted, exp_ab);
        check("left_end", steps_left, 0);
        exp_pos += dir ? exp_t.size() : -exp_t.size();
`ifdef POSITION_TRACK_EN
        check("pos_out", 64'(pos_out), 64'(exp_pos));
`endif
    endtask

    initial begin
        int s, d, k;
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulse", step_pulse, 0);
        check("rst_done", done, 0);
        check("rst_left", steps_left, 0);
        resetb = 1'b1;
        @(negedge clk);
        run_move(10, 40, 1, -1, 0);
        run_move(4, 20, 0, -1, 0);
        run_move(3, 150, 1, -1, 0);
        run_move(0, 40, 1, -1, 0);
        run_move(10, 40, 1, 4, 5);
        run_move(6, 5, 0, 0, 3);
        // reset mid-cruise, with a command offered while busy that must be ignored
        cmd_valid = 1'b1;
        cmd_steps = SW'(10);
        cmd_div   = DW'(150);
        cmd_dir   = 1'b1;
        @(negedge clk);
        cmd_steps = SW'(3);
        repeat (199) @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_left", steps_left, 9);
        resetb = 1'b0;
        #1;
        check("arst_pulse", step_pulse, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_left", steps_left, 0);
        check("arst_ready", cmd_ready, 1);
        exp_pos = 0;
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        run_move(10, 40, 1, -1, 0);
        run_move(4, 40, 0, -1, 0);
        for (int i = 0; i < 20; i++) begin
            s = $urandom_range(0, 10);
            d = $urandom_range(0, 170);
            k = ($urandom_range(0, 2) == 0 && s > 0) ? $urandom_range(0, s - 1) : -1;
            run_move(s, d, 1'($urandom_range(0, 1)), k, $urandom_range(1, 15));
        end
`ifdef POSITION_TRACK_EN
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        exp_pos = 0;
        check("pos_clr", 64'(pos_out), 64'(exp_pos));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
